// File: rtl/wb_sequencer_if.sv
// Issue/writeback handshake bundle between the datapath controller and wb_sequencer.
// Signal names match the sequencer's original port list.
interface wb_sequencer_if;
  logic       start;
  logic [2:0] op_class;
  logic       mem_ready;
  logic       overflow;
  logic       busy;
  logic       done;
  logic [2:0] mux_sel;
  logic       reg_write;
  logic       epc_write;
  logic       exc;
  logic [1:0] exc_cause;

  modport master (
    output start, op_class, mem_ready, overflow,
    input  busy, done, mux_sel, reg_write, epc_write, exc, exc_cause
  );

  modport slave (
    input  start, op_class, mem_ready, overflow,
    output busy, done, mux_sel, reg_write, epc_write, exc, exc_cause
  );
endinterface

// File: rtl/wb_sequencer.sv
// Multi-cycle writeback sequencer: issues one instruction, waits on memory for loads,
// then pulses either a register writeback or an exception with EPC capture.
module wb_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic            clk,
  input logic            reset_n,
  wb_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

  localparam logic [2:0] CL_LOAD    = 3'd0;
  localparam logic [2:0] CL_ALU     = 3'd1;
  localparam logic [2:0] CL_ALUOUT  = 3'd3;
  localparam logic [2:0] CL_NO_WB   = 3'd6;
  localparam logic [2:0] CL_ILLEGAL = 3'd7;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM_WAIT,
    S_WB,
    S_EXC
  } state_e;

  state_e           state_q,     state_d;
  logic [2:0]       class_q,     class_d;
  logic [1:0]       cause_q,     cause_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [2:0]       mux_sel_q,   mux_sel_d;
  logic             reg_write_q, reg_write_d;
  logic             epc_write_q, epc_write_d;
  logic             exc_q,       exc_d;

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          class_d = bus.op_class;
          if (bus.op_class == CL_ILLEGAL) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = S_EXC;
          end else begin
            cause_d = CAUSE_NONE;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (bus.overflow && (class_q == CL_ALU || class_q == CL_ALUOUT)) begin
          cause_d = CAUSE_OVERFLOW;
          state_d = S_EXC;
        end else if (class_q == CL_LOAD) begin
          cnt_d   = '0;
          state_d = S_MEM_WAIT;
        end else if (class_q == CL_NO_WB) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_WAIT: begin
        // Data arriving on the final allowed cycle still wins over the timeout.
        if (bus.mem_ready) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_MAX) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_EXC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it,
  // giving Moore behaviour without a combinational path to the ports.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_WB) || (state_d == S_EXEC && class_d == CL_NO_WB);
    mux_sel_d   = (state_d == S_WB) ? class_d : '0;
    reg_write_d = (state_d == S_WB);
    epc_write_d = (state_d == S_EXC);
    exc_d       = (state_d == S_EXC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      class_q     <= '0;
      cause_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mux_sel_q   <= '0;
      reg_write_q <= 1'b0;
      epc_write_q <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mux_sel_q   <= mux_sel_d;
      reg_write_q <= reg_write_d;
      epc_write_q <= epc_write_d;
      exc_q       <= exc_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mux_sel   = mux_sel_q;
  assign bus.reg_write = reg_write_q;
  assign bus.epc_write = epc_write_q;
  assign bus.exc       = exc_q;
  assign bus.exc_cause = cause_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: each instruction is expanded into the per-cycle
// output sequence it must produce, and a monitor checks every cycle against it.
module tb_wb_sequencer;

  localparam int MAXW = 15;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] mux;
    logic       rw;
    logic       epcw;
    logic       exc;
    logic [1:0] cause;
  } vec_t;

  logic clk;
  logic reset_n;
  wb_sequencer_if bus ();

  wb_sequencer #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt = 0, rw_cnt = 0, epc_cnt = 0, exc_cnt = 0, done_cnt = 0;
  int   held_cause = 0;
  vec_t exp_q[$];

  function automatic vec_t actual();
    vec_t v;
    v.busy  = bus.busy;
    v.done  = bus.done;
    v.mux   = bus.mux_sel;
    v.rw    = bus.reg_write;
    v.epcw  = bus.epc_write;
    v.exc   = bus.exc;
    v.cause = bus.exc_cause;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v_idle(input int cause);
    vec_t v = '0;
    v.cause = cause[1:0];
    return v;
  endfunction

  function automatic vec_t v_exec(input bit no_wb);
    vec_t v = '0;
    v.busy = 1'b1;
    v.done = no_wb;
    return v;
  endfunction

  function automatic vec_t v_mw();
    vec_t v = '0;
    v.busy = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_wb(input int c);
    vec_t v = '0;
    v.busy = 1'b1;
    v.done = 1'b1;
    v.mux  = c[2:0];
    v.rw   = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_exc(input int cause);
    vec_t v = '0;
    v.busy  = 1'b1;
    v.epcw  = 1'b1;
    v.exc   = 1'b1;
    v.cause = cause[1:0];
    return v;
  endfunction

  // Single compare process: one expected vector per clock while the queue is fed.
  always @(posedge clk) begin
    vec_t a;
    #2;
    a = actual();
    if (a.busy) busy_cnt++;
    if (a.rw)   rw_cnt++;
    if (a.epcw) epc_cnt++;
    if (a.exc)  exc_cnt++;
    if (a.done) done_cnt++;
    if (exp_q.size() > 0) chk("cycle_vec", int'(a), int'(exp_q.pop_front()));
  end

  task automatic step(input bit s, input logic [2:0] op, input bit ov, input bit rdy,
                      input vec_t e);
    @(negedge clk);
    bus.start     = s;
    bus.op_class  = op;
    bus.overflow  = ov;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // rdy_at: MEM_WAIT cycle (1-based) in which mem_ready is high; 0 means never.
  task automatic run_op(input int c, input bit ovf, input int rdy_at, input bit extra);
    logic [2:0] cl;
    bit         fin;
    cl = c[2:0];
    if (c == 7) begin
      held_cause = 2;
      step(1'b1, cl, 1'b0, 1'b0, v_exc(2));
    end else begin
      held_cause = 0;
      step(1'b1, cl, 1'b0, 1'b0, v_exec(c == 6));
      if (c == 6) begin
        step(extra, 3'd7, ovf, 1'b0, v_idle(0));
      end else if (ovf && (c == 1 || c == 3)) begin
        held_cause = 1;
        step(extra, 3'd7, 1'b1, 1'b0, v_exc(1));
      end else if (c == 0) begin
        step(extra, 3'd7, ovf, 1'b0, v_mw());
        fin = 1'b0;
        for (int j = 1; j <= MAXW + 1; j++) begin
          if (!fin) begin
            if (j == rdy_at) begin
              step(extra, 3'd7, 1'b0, 1'b1, v_wb(0));
              fin = 1'b1;
            end else if (j == MAXW + 1) begin
              held_cause = 3;
              step(extra, 3'd7, 1'b0, 1'b0, v_exc(3));
              fin = 1'b1;
            end else begin
              step(extra, 3'd7, 1'b0, 1'b0, v_mw());
            end
          end
        end
      end else begin
        step(extra, 3'd7, ovf, 1'b0, v_wb(c));
      end
    end
    step(1'b0, 3'd0, 1'b0, 1'b0, v_idle(held_cause));
    settle();
  endtask

  int b0, r0, e0, d0;

  task automatic snap();
    b0 = busy_cnt; r0 = rw_cnt; e0 = epc_cnt; d0 = done_cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.op_class = '0; bus.mem_ready = 1'b0; bus.overflow = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("reset_state", int'(actual()), 0);
    @(negedge clk);
    reset_n = 1'b1;

    snap();
    run_op(1, 1'b0, 0, 1'b0);
    chk("alu_busy_cycles", busy_cnt - b0, 2);
    chk("alu_rw_pulses", rw_cnt - r0, 1);

    snap();
    run_op(0, 1'b0, 4, 1'b0);
    chk("load4_busy_cycles", busy_cnt - b0, 6);
    chk("load4_rw_pulses", rw_cnt - r0, 1);

    snap();
    run_op(0, 1'b0, 0, 1'b0);
    chk("timeout_busy_cycles", busy_cnt - b0, 18);
    chk("timeout_epc_pulses", epc_cnt - e0, 1);
    chk("timeout_rw_pulses", rw_cnt - r0, 0);
    chk("timeout_cause_held", int'(bus.exc_cause), 3);

    snap();
    run_op(0, 1'b0, 16, 1'b0);
    chk("load16_busy_cycles", busy_cnt - b0, 18);
    chk("load16_rw_pulses", rw_cnt - r0, 1);
    chk("load16_epc_pulses", epc_cnt - e0, 0);

    snap();
    run_op(3, 1'b1, 0, 1'b0);
    chk("ovf_cause", int'(bus.exc_cause), 1);
    chk("ovf_rw_pulses", rw_cnt - r0, 0);

    snap();
    run_op(7, 1'b0, 0, 1'b0);
    chk("illegal_busy_cycles", busy_cnt - b0, 1);
    chk("illegal_cause", int'(bus.exc_cause), 2);

    snap();
    run_op(2, 1'b1, 0, 1'b1);
    chk("link_single_wb", rw_cnt - r0, 1);
    chk("link_no_exc", epc_cnt - e0, 0);

    snap();
    run_op(6, 1'b0, 0, 1'b1);
    chk("nowb_busy_cycles", busy_cnt - b0, 1);
    chk("nowb_done_pulses", done_cnt - d0, 1);
    chk("nowb_rw_pulses", rw_cnt - r0, 0);

    run_op(4, 1'b0, 0, 1'b0);
    run_op(5, 1'b0, 0, 1'b1);
    run_op(1, 1'b1, 0, 1'b0);
    run_op(0, 1'b1, 2, 1'b1);
    run_op(0, 1'b0, 1, 1'b0);

    // Reset mid-load: outputs must clear asynchronously and nothing may fire afterwards.
    held_cause = 0;
    step(1'b1, 3'd0, 1'b0, 1'b0, v_exec(1'b0));
    step(1'b0, 3'd0, 1'b0, 1'b0, v_mw());
    step(1'b0, 3'd0, 1'b0, 1'b0, v_mw());
    @(posedge clk);
    #4;
    snap();
    reset_n = 1'b0;
    #1;
    chk("async_reset_vec", int'(actual()), 0);
    @(posedge clk);
    #2;
    chk("reset_held_vec", int'(actual()), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) step(1'b0, 3'd0, 1'b0, 1'b1, v_idle(0));
    settle();
    chk("post_reset_rw", rw_cnt - r0, 0);
    chk("post_reset_epc", epc_cnt - e0, 0);
    chk("post_reset_busy", busy_cnt - b0, 0);

    run_op(1, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
